sram_wr_sched: RTL and testbench
================================

Name: sram_wr_sched

Overview:
- Write-port scheduler for the shared 128-bit activation SRAM in the CNN datapath.
- Two requesters share one SRAM write port:
  - Port A: the UNSHUFFLE pixel writer (single-byte writes).
  - Port B: the CONV result writer (4-byte lane or full-word writes).
- Arbitrates between them, converts each accepted request into address, write data and an active-low bytemask, and registers the result as the SRAM write-port drive.
- Sits between the top-level layer FSM and the SRAM macro.

Parameters:
- LAYER1_WIDTH, 14, image width in pixels (x range).
- LAYER1_HEIGHT, 14, image height in pixels (y range).
- ADDR_W, 10, SRAM word-address width.
- BURST_MAX, 4, maximum consecutive beats granted to one requester while the other is waiting (at least 1).
- CNT_W, 10, width of each per-port write counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- en  in  1  scheduler enable (driven by the top FSM in UNSHUFFLE/CONV states)
- clear  in  1  zero both write counters
- a_valid  in  1  unshuffle request valid
- a_ready  out  1  unshuffle request accepted this cycle
- a_x  in  5  pixel column
- a_y  in  5  pixel row
- a_pix  in  8  pixel value
- b_valid  in  1  conv request valid
- b_ready  out  1  conv request accepted this cycle
- b_addr  in  ADDR_W  word address
- b_data  in  128  write data
- b_full  in  1  1 = write all 16 bytes
- b_lane  in  2  4-byte group index, used when b_full=0
- sram_addr  out  ADDR_W  write address
- sram_wdata  out  128  write data
- sram_bytemask  out  16  active-low byte enables; bit k covers wdata[8k+7:8k]
- wr_cnt_a  out  CNT_W  writes issued for port A
- wr_cnt_b  out  CNT_W  writes issued for port B
- busy  out  1  a grant is held (state is not IDLE)

Behaviour:
- Clocking and reset:
  - Single clock domain, clk.
  - Reset is synchronous and active-high on rst.
- Reset values:
  - sram_bytemask=16'hFFFF; sram_addr=0; sram_wdata=0.
  - Counters=0; state=IDLE; beat count=0; last-served=B.
- Handshake and latency:
  - A transfer happens on valid&ready.
  - a_ready/b_ready are combinational and one-hot-or-zero; both are 0 when en=0 or rst=1.
  - The SRAM outputs reflect the transfer one cycle later.
  - In any cycle with no transfer, the next sram_bytemask is 16'hFFFF. addr and wdata hold their last values.
- FSM states: IDLE, GNT_A, GNT_B.
- Owner selection, evaluated each cycle with en=1:
  - If in GNT_X, X still valid, and beat count < BURST_MAX, X keeps ownership.
  - Otherwise arbitrate:
    - Only one requester valid: it wins.
    - Both valid after burst exhaustion: the other requester wins.
    - Both valid from IDLE or after a drop: tie rule (see Optional Feature).
  - No valid requester: go to IDLE.
  - Beat count resets to 1 on an ownership change and increments on each owner transfer.
- en=0: FSM state, beat count and counters are frozen.
- Port A mapping:
  - Word address = (a_y>>2)*((LAYER1_WIDTH+3)>>2) + (a_x>>2).
  - offset = (a_y%4)*4 + (a_x%4).
  - Table L[offset] = {0,4,1,5,8,12,9,13,2,6,3,7,10,14,11,15}.
  - lane = 15 - L[offset]; the mask clears only bit lane; a_pix goes to wdata byte lane, all other bytes are 0.
  - If a_x >= LAYER1_WIDTH or a_y >= LAYER1_HEIGHT: the request is still accepted, the mask is 16'hFFFF, and wr_cnt_a does not increment.
- Port B mapping:
  - b_full=1: mask 16'h0000.
  - b_full=0: mask bits [15-4*b_lane -: 4] cleared, all others set.
  - addr and data pass through.
- Counters:
  - Each counter increments when a mask other than 16'hFFFF is issued for its port.
  - Counters wrap at 2^CNT_W.
  - clear zeroes both counters; if clear and an increment occur in the same cycle, clear wins.
- Reset mid-burst: outputs return to reset values on the next edge; the in-flight transfer is dropped.

Optional Feature:
- Macro: SRAM_WR_SCHED_RR_EN.
- Defined: ties go to the requester that is not last-served (round-robin).
- Not defined: ties always go to B (conv has priority).
- Burst-exhaustion handover behaves identically in both builds.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles, both valid=1.
  - Required: a_ready=b_ready=0, sram_bytemask=16'hFFFF, counters=0, busy=0.
- Unshuffle pixel:
  - Stimulus: en=1, a_x=5, a_y=6, a_pix=8'hAB.
  - Required, next cycle: sram_addr=5, sram_bytemask=16'hFDFF, sram_wdata[79:72]=8'hAB, wr_cnt_a=1.
- Conv lane and full-word writes:
  - Stimulus: b_addr=10'h040, b_full=0, b_lane=2.
  - Required: mask 16'hFF0F, addr 10'h040.
  - Then b_full=1 → mask 16'h0000; wr_cnt_b=2.
- Contention, both valid for 16 cycles, BURST_MAX=4:
  - Default build: B×4, A×4, B×4, A×4.
  - Round-robin build starting from last-served=B: A×4, B×4, A×4, B×4.
- Stall and out-of-range:
  - Stimulus: en=0 for 3 cycles mid-burst.
  - Required: ready=0, mask FFFF, beat count held; the burst resumes with the remaining beats.
  - Stimulus: a_x=14.
  - Required: accepted, mask FFFF, wr_cnt_a unchanged.
- Clear and reset collisions:
  - Stimulus: clear together with a B transfer.
  - Required: wr_cnt_b=0.
  - Stimulus: rst asserted during the 2nd beat of a burst.
  - Required: next cycle mask FFFF, state IDLE, counters 0.

Source files
------------

// File: rtl/sram_wr_sched.sv
// Purpose : write-port scheduler for the shared 128-bit activation SRAM (unshuffle port A, conv port B).
// Latency : SRAM address/data/bytemask are registered, one cycle after the valid&ready transfer.
// Backpres: a_ready/b_ready are combinational and one-hot-or-zero; both are low when en=0 or rst=1.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   en, clear              scheduler enable (freezes FSM/beat/counters when low), zero both write counters
//   a_valid/a_ready        unshuffle pixel request: a_x, a_y (pixel coordinates), a_pix (pixel value)
//   b_valid/b_ready        conv request: b_addr, b_data, b_full (all 16 bytes), b_lane (4-byte group)
//   sram_addr/sram_wdata   registered SRAM write address and data
//   sram_bytemask          registered active-low byte enables (bit k covers wdata[8k+7:8k])
//   wr_cnt_a/wr_cnt_b      writes actually issued per port (wrapping)
//   busy                   a grant is held
//
// Build option: define SRAM_WR_SCHED_RR_EN to resolve ties round-robin instead of always favouring port B.

module sram_wr_sched #(
  parameter int LAYER1_WIDTH  = 14,
  parameter int LAYER1_HEIGHT = 14,
  parameter int ADDR_W        = 10,
  parameter int BURST_MAX     = 4,
  parameter int CNT_W         = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [4:0]        a_x,
  input  logic [4:0]        a_y,
  input  logic [7:0]        a_pix,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [127:0]      b_data,
  input  logic              b_full,
  input  logic [1:0]        b_lane,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [127:0]      sram_wdata,
  output logic [15:0]       sram_bytemask,
  output logic [CNT_W-1:0]  wr_cnt_a,
  output logic [CNT_W-1:0]  wr_cnt_b,
  output logic              busy
);

  // Each SRAM word holds a 4x4 pixel tile; this many tiles span one image row band.
  localparam int WORDS_X = (LAYER1_WIDTH + 3) >> 2;
  localparam int BEAT_W  = $clog2(BURST_MAX + 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_MAX);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  state_t            state, state_nxt;
  logic [BEAT_W-1:0] beat, beat_nxt;
  logic              grant_a, grant_b;
  logic              burst_left;

`ifdef SRAM_WR_SCHED_RR_EN
  logic              last_b;  // 1 = port B was served most recently
`endif

  // Port A mapping
  logic [ADDR_W-1:0] a_word;
  logic [3:0]        a_off;
  logic [3:0]        a_lane;
  logic              a_in_range;
  logic [15:0]       a_mask;
  logic [127:0]      a_wdata;

  // Port B mapping
  logic [15:0]       b_mask;

  // Position of a pixel inside its 4x4 tile -> interleaved byte order used by the conv datapath.
  function automatic logic [3:0] tile_order(input logic [3:0] off);
    logic [3:0] r;
    case (off)
      4'd0:  r = 4'd0;
      4'd1:  r = 4'd4;
      4'd2:  r = 4'd1;
      4'd3:  r = 4'd5;
      4'd4:  r = 4'd8;
      4'd5:  r = 4'd12;
      4'd6:  r = 4'd9;
      4'd7:  r = 4'd13;
      4'd8:  r = 4'd2;
      4'd9:  r = 4'd6;
      4'd10: r = 4'd3;
      4'd11: r = 4'd7;
      4'd12: r = 4'd10;
      4'd13: r = 4'd14;
      4'd14: r = 4'd11;
      default: r = 4'd15;
    endcase
    return r;
  endfunction

  always_comb begin
    a_word     = ADDR_W'(a_y[4:2]) * ADDR_W'(WORDS_X) + ADDR_W'(a_x[4:2]);
    a_off      = {a_y[1:0], a_x[1:0]};
    a_lane     = 4'd15 - tile_order(a_off);
    a_in_range = (int'(a_x) < LAYER1_WIDTH) && (int'(a_y) < LAYER1_HEIGHT);
    // Out-of-image pixels are consumed but never written.
    a_mask     = a_in_range ? ~(16'h0001 << a_lane) : 16'hFFFF;
    a_wdata    = 128'(a_pix) << {a_lane, 3'b000};
  end

  always_comb begin
    b_mask = 16'hFFFF;
    if (b_full) begin
      b_mask = 16'h0000;
    end else begin
      case (b_lane)
        2'd0:    b_mask = 16'h0FFF;
        2'd1:    b_mask = 16'hF0FF;
        2'd2:    b_mask = 16'hFF0F;
        default: b_mask = 16'hFFF0;
      endcase
    end
  end

  // Owner selection. Beat count saturates at BURST_MAX: once exhausted the owner only
  // keeps the port if the other side is idle, so counting further carries no information.
  always_comb begin
    state_nxt  = state;
    beat_nxt   = beat;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    burst_left = (beat < BEAT_MAX);

    if (en && !rst) begin
      if (state == GNT_A && a_valid && burst_left) begin
        grant_a = 1'b1;
      end else if (state == GNT_B && b_valid && burst_left) begin
        grant_b = 1'b1;
      end else if (a_valid && b_valid) begin
        // Both valid while holding a grant can only mean the owner's burst ran out.
        if (state == GNT_A) begin
          grant_b = 1'b1;
        end else if (state == GNT_B) begin
          grant_a = 1'b1;
        end else begin
`ifdef SRAM_WR_SCHED_RR_EN
          if (last_b) grant_a = 1'b1;
          else        grant_b = 1'b1;
`else
          grant_b = 1'b1;
`endif
        end
      end else if (a_valid) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end

      if (grant_a)      state_nxt = GNT_A;
      else if (grant_b) state_nxt = GNT_B;
      else              state_nxt = IDLE;

      if (state_nxt == IDLE)       beat_nxt = '0;
      else if (state_nxt != state) beat_nxt = BEAT_W'(1);
      else if (burst_left)         beat_nxt = beat + BEAT_W'(1);
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      beat          <= '0;
      sram_addr     <= '0;
      sram_wdata    <= '0;
      sram_bytemask <= 16'hFFFF;
      wr_cnt_a      <= '0;
      wr_cnt_b      <= '0;
`ifdef SRAM_WR_SCHED_RR_EN
      last_b        <= 1'b1;
`endif
    end else begin
      if (en) begin
        state <= state_nxt;
        beat  <= beat_nxt;
`ifdef SRAM_WR_SCHED_RR_EN
        if (grant_a)      last_b <= 1'b0;
        else if (grant_b) last_b <= 1'b1;
`endif
      end

      if (grant_a) begin
        sram_addr     <= a_word;
        sram_wdata    <= a_wdata;
        sram_bytemask <= a_mask;
      end else if (grant_b) begin
        sram_addr     <= b_addr;
        sram_wdata    <= b_data;
        sram_bytemask <= b_mask;
      end else begin
        sram_bytemask <= 16'hFFFF;
      end

      if (clear)                      wr_cnt_a <= '0;
      else if (grant_a && a_in_range) wr_cnt_a <= wr_cnt_a + CNT_W'(1);

      if (clear)        wr_cnt_b <= '0;
      else if (grant_b) wr_cnt_b <= wr_cnt_b + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sram_wr_sched.sv
// Purpose : self-checking bench for sram_wr_sched against a rule-level reference model.
// Latency : model predicts ready in the request cycle and SRAM drive one cycle later.
// Backpres: directed scenarios from the block's feature list, then randomized traffic.

module tb_sram_wr_sched;

  localparam int W  = 14;
  localparam int H  = 14;
  localparam int AW = 10;
  localparam int BM = 4;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst, en, clear;
  logic          a_valid, a_ready, b_valid, b_ready, b_full;
  logic [4:0]    a_x, a_y;
  logic [7:0]    a_pix;
  logic [AW-1:0] b_addr;
  logic [127:0]  b_data;
  logic [1:0]    b_lane;
  logic [AW-1:0] sram_addr;
  logic [127:0]  sram_wdata;
  logic [15:0]   sram_bytemask;
  logic [CW-1:0] wr_cnt_a, wr_cnt_b;
  logic          busy;

  sram_wr_sched #(
    .LAYER1_WIDTH(W), .LAYER1_HEIGHT(H), .ADDR_W(AW), .BURST_MAX(BM), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .a_valid(a_valid), .a_ready(a_ready), .a_x(a_x), .a_y(a_y), .a_pix(a_pix),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .b_full(b_full), .b_lane(b_lane),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_bytemask(sram_bytemask),
    .wr_cnt_a(wr_cnt_a), .wr_cnt_b(wr_cnt_b), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: owner (0 none, 1 A, 2 B), length of current run, last served port.
  int            m_owner  = 0;
  int            m_run    = 0;
  bit            m_last_b = 1'b1;
  logic [15:0]   e_mask   = 16'hFFFF;
  logic [AW-1:0] e_addr   = '0;
  logic [127:0]  e_wdata  = '0;
  logic [CW-1:0] e_cnt_a  = '0;
  logic [CW-1:0] e_cnt_b  = '0;
  logic          obs_a, obs_b;

  int L[16] = '{0, 4, 1, 5, 8, 12, 9, 13, 2, 6, 3, 7, 10, 14, 11, 15};

  function automatic int tie_winner();
`ifdef SRAM_WR_SCHED_RR_EN
    return m_last_b ? 1 : 2;
`else
    return 2;
`endif
  endfunction

  function automatic int model_pick();
    bit owner_valid;
    if (rst || !en) return 0;
    owner_valid = (m_owner == 1 && a_valid) || (m_owner == 2 && b_valid);
    if (owner_valid && m_run < BM) return m_owner;
    if (a_valid && b_valid) return owner_valid ? (3 - m_owner) : tie_winner();
    if (a_valid) return 1;
    if (b_valid) return 2;
    return 0;
  endfunction

  // One clock: check the DUT at the falling edge, advance the model, return just after the rising edge.
  task automatic cycle();
    int p, lane;
    @(negedge clk);
    p = model_pick();
    check_eq("a_ready", a_ready, p == 1);
    check_eq("b_ready", b_ready, p == 2);
    check_eq("bytemask", sram_bytemask, e_mask);
    check_eq("addr", sram_addr, e_addr);
    check_eq("wdata", sram_wdata, e_wdata);
    check_eq("wr_cnt_a", wr_cnt_a, e_cnt_a);
    check_eq("wr_cnt_b", wr_cnt_b, e_cnt_b);
    check_eq("busy", busy, m_owner != 0);
    obs_a = a_ready;
    obs_b = b_ready;
    if (rst) begin
      m_owner = 0; m_run = 0; m_last_b = 1'b1;
      e_mask = 16'hFFFF; e_addr = '0; e_wdata = '0; e_cnt_a = '0; e_cnt_b = '0;
    end else begin
      if (en) begin
        if (p == 0)            begin m_owner = 0; m_run = 0; end
        else if (p == m_owner) m_run++;
        else                   begin m_owner = p; m_run = 1; end
        if (p != 0) m_last_b = (p == 2);
      end
      e_mask = 16'hFFFF;
      if (p == 1) begin
        lane    = 15 - L[(int'(a_y) % 4) * 4 + (int'(a_x) % 4)];
        e_addr  = AW'((int'(a_y) / 4) * ((W + 3) / 4) + int'(a_x) / 4);
        e_wdata = '0;
        e_wdata[8*lane +: 8] = a_pix;
        if (int'(a_x) < W && int'(a_y) < H) begin
          e_mask[lane] = 1'b0;
          e_cnt_a = e_cnt_a + 1'b1;
        end
      end else if (p == 2) begin
        e_addr  = b_addr;
        e_wdata = b_data;
        for (int k = 0; k < 16; k++)
          if (b_full || (k / 4) == (3 - int'(b_lane))) e_mask[k] = 1'b0;
        e_cnt_b = e_cnt_b + 1'b1;
      end
      if (clear) begin e_cnt_a = '0; e_cnt_b = '0; end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [CW-1:0] saved_cnt;
    bit            b_first;

    rst = 1'b1; en = 1'b0; clear = 1'b0;
    a_valid = 1'b1; a_x = 5'd0; a_y = 5'd0; a_pix = 8'h00;
    b_valid = 1'b1; b_addr = '0; b_data = '0; b_full = 1'b0; b_lane = 2'd0;
    @(posedge clk);
    #1;

    // Reset with both requesters valid.
    en = 1'b1;
    cycle();
    cycle();
    check_eq("rst_mask", sram_bytemask, 16'hFFFF);
    check_eq("rst_cnt_a", wr_cnt_a, 0);
    check_eq("rst_cnt_b", wr_cnt_b, 0);
    check_eq("rst_busy", busy, 1'b0);

    // Single unshuffle pixel.
    rst = 1'b0; b_valid = 1'b0;
    a_x = 5'd5; a_y = 5'd6; a_pix = 8'hAB;
    cycle();
    check_eq("px_addr", sram_addr, 5);
    check_eq("px_mask", sram_bytemask, 16'hFDFF);
    check_eq("px_byte", sram_wdata[79:72], 8'hAB);
    check_eq("px_cnt", wr_cnt_a, 1);

    // Conv lane then full-word writes.
    a_valid = 1'b0;
    b_valid = 1'b1; b_addr = 10'h040; b_full = 1'b0; b_lane = 2'd2;
    b_data = {$urandom, $urandom, $urandom, $urandom};
    cycle();
    check_eq("lane_mask", sram_bytemask, 16'hFF0F);
    check_eq("lane_addr", sram_addr, 10'h040);
    b_full = 1'b1;
    cycle();
    check_eq("full_mask", sram_bytemask, 16'h0000);
    check_eq("full_cnt", wr_cnt_b, 2);

    // Contention from IDLE, last served = B.
    b_valid = 1'b0;
    cycle();
    a_valid = 1'b1; b_valid = 1'b1; a_x = 5'd1; a_y = 5'd1;
`ifdef SRAM_WR_SCHED_RR_EN
    b_first = 1'b0;
`else
    b_first = 1'b1;
`endif
    for (int i = 0; i < 16; i++) begin
      cycle();
      check_eq($sformatf("contend%0d", i), {obs_a, obs_b},
               ((((i / 4) % 2) == 0) == b_first) ? 2'b01 : 2'b10);
    end

    // Stall mid-burst: B takes 2 beats, 3 disabled cycles, then the remaining 2 beats before A.
    a_valid = 1'b0; b_valid = 1'b0;
    cycle();
    b_valid = 1'b1; b_full = 1'b0; b_lane = 2'd1;
    cycle();
    cycle();
    en = 1'b0; a_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq($sformatf("stall_rdy%0d", i), {obs_a, obs_b}, 2'b00);
      check_eq($sformatf("stall_mask%0d", i), sram_bytemask, 16'hFFFF);
    end
    en = 1'b1;
    cycle();
    check_eq("resume0", {obs_a, obs_b}, 2'b01);
    cycle();
    check_eq("resume1", {obs_a, obs_b}, 2'b01);
    cycle();
    check_eq("resume2", {obs_a, obs_b}, 2'b10);

    // Out-of-range pixel is accepted but not written.
    b_valid = 1'b0; a_x = 5'd14; a_y = 5'd3;
    saved_cnt = e_cnt_a;
    cycle();
    check_eq("oor_accept", obs_a, 1'b1);
    check_eq("oor_mask", sram_bytemask, 16'hFFFF);
    check_eq("oor_cnt", wr_cnt_a, saved_cnt);

    // Clear coincident with a B transfer.
    a_valid = 1'b0; b_valid = 1'b1; b_full = 1'b1; clear = 1'b1;
    cycle();
    clear = 1'b0;
    check_eq("clr_mask", sram_bytemask, 16'h0000);
    check_eq("clr_cnt_b", wr_cnt_b, 0);

    // Reset during the 2nd beat of a burst.
    a_valid = 1'b1; a_x = 5'd2; a_y = 5'd2; b_valid = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; a_valid = 1'b0;
    check_eq("rstb_mask", sram_bytemask, 16'hFFFF);
    check_eq("rstb_busy", busy, 1'b0);
    check_eq("rstb_cnt_a", wr_cnt_a, 0);
    check_eq("rstb_cnt_b", wr_cnt_b, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 49) == 0);
      en      = ($urandom_range(0, 9) != 0);
      clear   = ($urandom_range(0, 19) == 0);
      a_valid = ($urandom_range(0, 9) < 6);
      b_valid = ($urandom_range(0, 9) < 6);
      a_x     = 5'($urandom_range(0, 15));
      a_y     = 5'($urandom_range(0, 15));
      a_pix   = 8'($urandom);
      b_addr  = AW'($urandom);
      b_data  = {$urandom, $urandom, $urandom, $urandom};
      b_full  = 1'($urandom);
      b_lane  = 2'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
